// File: rtl/kbd_pkg.sv
// Shared HID usage codes and FSM encoding for the keycode report builder.
// Used by keycode_report_builder and krb_slot_match.
package kbd_pkg;

  localparam logic [7:0] KEY_NONE         = 8'h00;
  localparam logic [7:0] KEY_ERR_ROLLOVER = 8'h01;
  localparam logic [7:0] KEY_A            = 8'h04;
  localparam logic [7:0] KEY_D            = 8'h07;
  localparam logic [7:0] KEY_S            = 8'h16;
  localparam logic [7:0] KEY_W            = 8'h1A;

  typedef enum logic [1:0] {
    IDLE,
    MATCH,
    UPDATE
  } krb_state_t;

endpackage

// File: rtl/krb_slot_match.sv
// Combinational lookup of one code against the held-key table.
// Reports whether the code is held and where it sits, and the lowest empty slot.
module krb_slot_match #(
  parameter int NUM_SLOTS = 4,
  parameter int IDX_W     = 2
) (
  input  logic [NUM_SLOTS-1:0][7:0] key_table,
  input  logic [7:0]                code,
  output logic                      hit,
  output logic [IDX_W-1:0]          hit_idx,
  output logic                      has_free,
  output logic [IDX_W-1:0]          free_idx
);
  import kbd_pkg::*;

  // Walk from the top slot down so the lowest matching index wins.
  always_comb begin
    hit      = 1'b0;
    hit_idx  = '0;
    has_free = 1'b0;
    free_idx = '0;
    for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
      if (key_table[i] == code) begin
        hit     = 1'b1;
        hit_idx = IDX_W'(i);
      end
      if (key_table[i] == KEY_NONE) begin
        has_free = 1'b1;
        free_idx = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/keycode_report_builder.sv
// Held-key table fed by make/break events (accept -> table update in 3 edges, one event per 3 cycles).
// Snapshot onto keycode on frame_tick; KRB_ROLLOVER_EN adds the overflow counter and 8'h01 error fill.
module keycode_report_builder #(
  parameter int NUM_SLOTS = 4
`ifdef KRB_ROLLOVER_EN
  , parameter int OVF_W   = 4
`endif
) (
  input  logic                   Clk,
  input  logic                   Reset_n,
  input  logic                   ev_valid,
  input  logic [7:0]             ev_code,
  input  logic                   ev_make,
  output logic                   ev_ready,
  input  logic                   frame_tick,
  input  logic                   clear,
  output logic [8*NUM_SLOTS-1:0] keycode,
  output logic [2:0]             key_count,
  output logic                   rollover
);
  import kbd_pkg::*;

  localparam int IDX_W = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;

  krb_state_t state_q, state_d;

  logic [NUM_SLOTS-1:0][7:0] key_table;
  logic [NUM_SLOTS-1:0][7:0] table_shr;
  logic [7:0]                ev_code_q;
  logic                      ev_make_q;
  logic                      accept;
  logic                      upd_vld;
  logic                      snapshot_err;

  logic             hit_c, has_free_c;
  logic [IDX_W-1:0] hit_idx_c, free_idx_c;
  logic             hit_q, has_free_q;
  logic [IDX_W-1:0] hit_idx_q, free_idx_q;

  assign ev_ready  = (state_q == IDLE) && Reset_n && !clear;
  assign accept    = ev_valid && ev_ready;
  assign upd_vld   = (state_q == UPDATE) && (ev_code_q != KEY_NONE);
  assign table_shr = key_table >> 8;

  always_ff @(posedge Clk) begin
    if (!Reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (clear) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    if (accept) state_d = MATCH;
        MATCH:   state_d = UPDATE;
        UPDATE:  state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      ev_code_q <= KEY_NONE;
      ev_make_q <= 1'b0;
    end else if (accept) begin
      ev_code_q <= ev_code;
      ev_make_q <= ev_make;
    end
  end

  krb_slot_match #(
    .NUM_SLOTS (NUM_SLOTS),
    .IDX_W     (IDX_W)
  ) u_match (
    .key_table (key_table),
    .code      (ev_code_q),
    .hit       (hit_c),
    .hit_idx   (hit_idx_c),
    .has_free  (has_free_c),
    .free_idx  (free_idx_c)
  );

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      hit_q      <= 1'b0;
      hit_idx_q  <= '0;
      has_free_q <= 1'b0;
      free_idx_q <= '0;
    end else if (state_q == MATCH) begin
      hit_q      <= hit_c;
      hit_idx_q  <= hit_idx_c;
      has_free_q <= has_free_c;
      free_idx_q <= free_idx_c;
    end
  end

  // A break closes the gap by pulling every higher slot down one, keeping press order.
  always_ff @(posedge Clk) begin
    if (!Reset_n || clear) begin
      key_table <= '0;
      key_count <= '0;
    end else if (upd_vld) begin
      if (ev_make_q) begin
        if (!hit_q && has_free_q) begin
          key_table[free_idx_q] <= ev_code_q;
          key_count             <= key_count + 3'd1;
        end
      end else if (hit_q) begin
        for (int i = 0; i < NUM_SLOTS; i++) begin
          if (i >= int'(hit_idx_q)) key_table[i] <= table_shr[i];
        end
        key_count <= key_count - 3'd1;
      end
    end
  end

`ifdef KRB_ROLLOVER_EN
  logic [OVF_W-1:0] ovf_q, ovf_d;

  always_comb begin
    ovf_d = ovf_q;
    if (upd_vld && !hit_q) begin
      if (ev_make_q && !has_free_q && (ovf_q != '1)) ovf_d = ovf_q + 1'b1;
      else if (!ev_make_q && (ovf_q != '0))          ovf_d = ovf_q - 1'b1;
    end
  end

  always_ff @(posedge Clk) begin
    if (!Reset_n || clear) begin
      ovf_q    <= '0;
      rollover <= 1'b0;
    end else begin
      ovf_q    <= ovf_d;
      rollover <= (ovf_d != '0);
    end
  end

  assign snapshot_err = (ovf_q != '0);
`else
  assign rollover     = 1'b0;
  assign snapshot_err = 1'b0;
`endif

  // Snapshot reflects the table as registered before any same-edge update or clear.
  always_ff @(posedge Clk) begin
    if (!Reset_n)        keycode <= '0;
    else if (frame_tick) keycode <= snapshot_err ? {NUM_SLOTS{KEY_ERR_ROLLOVER}} : key_table;
  end

endmodule

// File: tb/tb_keycode_report_builder.sv
// Directed scenarios plus randomized traffic against a queue-based model of the held-key table.
module tb_keycode_report_builder;
  import kbd_pkg::*;

  logic        clk = 1'b0;
  logic        Reset_n = 1'b0;
  logic        ev_valid = 1'b0;
  logic [7:0]  ev_code = 8'h00;
  logic        ev_make = 1'b0;
  logic        ev_ready;
  logic        frame_tick = 1'b0;
  logic        clear = 1'b0;
  logic [31:0] keycode;
  logic [2:0]  key_count;
  logic        rollover;

  int n_cmp = 0;
  int n_mis = 0;
  bit chk_en = 1'b0;

  keycode_report_builder dut (
    .Clk        (clk),
    .Reset_n    (Reset_n),
    .ev_valid   (ev_valid),
    .ev_code    (ev_code),
    .ev_make    (ev_make),
    .ev_ready   (ev_ready),
    .frame_tick (frame_tick),
    .clear      (clear),
    .keycode    (keycode),
    .key_count  (key_count),
    .rollover   (rollover)
  );

  always #5 clk = ~clk;

`ifdef KRB_ROLLOVER_EN
  localparam bit ROLL_EN = 1'b1;
`else
  localparam bit ROLL_EN = 1'b0;
`endif

  // Reference model: held keys in press order, untracked-key count, pending event.
  byte unsigned held[$];
  int           ovf = 0;
  logic [31:0]  exp_kc = '0;
  bit           pend = 1'b0;
  int           pend_cnt = 0;
  logic [7:0]   p_code = 8'h00;
  logic         p_make = 1'b0;
  bit           m_acc;

  function automatic logic [31:0] pack_held();
    logic [31:0] v;
    v = '0;
    for (int i = 0; i < held.size(); i++) v[8*i +: 8] = held[i];
    return v;
  endfunction

  function automatic void apply_event();
    int idx;
    idx = -1;
    if (p_code == 8'h00) return;
    for (int i = 0; i < held.size(); i++) if (held[i] == p_code) idx = i;
    if (p_make) begin
      if (idx >= 0) return;
      if (held.size() < 4) held.push_back(p_code);
      else if (ROLL_EN && ovf < 15) ovf++;
    end else begin
      if (idx >= 0) held.delete(idx);
      else if (ROLL_EN && ovf > 0) ovf--;
    end
  endfunction

  always @(posedge clk) begin
    m_acc = ev_valid && Reset_n && !clear && !pend;
    if (!Reset_n) begin
      held.delete();
      ovf    = 0;
      exp_kc = '0;
      pend   = 1'b0;
    end else begin
      if (frame_tick) exp_kc = (ovf != 0) ? 32'h01010101 : pack_held();
      if (clear) begin
        held.delete();
        ovf  = 0;
        pend = 1'b0;
      end else begin
        if (pend) begin
          pend_cnt--;
          if (pend_cnt == 0) begin
            apply_event();
            pend = 1'b0;
          end
        end
        if (m_acc) begin
          pend     = 1'b1;
          pend_cnt = 2;
          p_code   = ev_code;
          p_make   = ev_make;
        end
      end
    end
  end

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endfunction

  always @(negedge clk) begin
    if (chk_en) begin
      chk("ev_ready",  {31'b0, ev_ready},  {31'b0, (Reset_n && !clear && !pend)});
      chk("keycode",   keycode,            exp_kc);
      chk("key_count", {29'b0, key_count}, 32'(held.size()));
      chk("rollover",  {31'b0, rollover},  {31'b0, (ovf != 0)});
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) step();
  endtask

  task automatic tick();
    frame_tick = 1'b1;
    step();
    frame_tick = 1'b0;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    step();
    clear = 1'b0;
  endtask

  // Returns one cycle after the accepting edge (block is then matching).
  task automatic send(input logic [7:0] c, input logic m);
    int n;
    n = 0;
    ev_valid = 1'b1;
    ev_code  = c;
    ev_make  = m;
    #1;
    while (!ev_ready && n < 20) begin
      step();
      #1;
      n++;
    end
    if (n >= 20) begin
      n_cmp++;
      n_mis++;
      $display("FAIL send_timeout: ev_ready stayed 0 for code %h", c);
    end
    step();
    ev_valid = 1'b0;
  endtask

  int acc_cnt;
  logic [7:0] codes[8];

  initial begin
    codes[0] = 8'h00; codes[1] = KEY_A; codes[2] = KEY_D; codes[3] = KEY_S;
    codes[4] = KEY_W; codes[5] = 8'h2C; codes[6] = 8'h05; codes[7] = 8'h08;

    // Reset held two cycles
    step();
    chk_en = 1'b1;
    step();
    chk("rst_keycode", keycode, 32'h0);
    chk("rst_key_count", {29'b0, key_count}, 32'd0);
    chk("rst_rollover", {31'b0, rollover}, 32'd0);
    chk("rst_ev_ready", {31'b0, ev_ready}, 32'd0);
    Reset_n = 1'b1;
    #1;
    chk("post_rst_ev_ready", {31'b0, ev_ready}, 32'd1);
    step();

    // Press order preserved, break shifts down
    send(KEY_W, 1'b1);
    send(KEY_A, 1'b1);
    send(KEY_S, 1'b1);
    idle(3);
    tick();
    chk("order_keycode", keycode, 32'h0016041A);
    chk("order_key_count", {29'b0, key_count}, 32'd3);
    send(KEY_A, 1'b0);
    idle(3);
    tick();
    chk("break_keycode", keycode, 32'h0000161A);

    // Duplicate make and null code
    do_clear();
    send(KEY_D, 1'b1);
    send(KEY_D, 1'b1);
    send(KEY_NONE, 1'b1);
    idle(3);
    chk("dup_key_count", {29'b0, key_count}, 32'd1);
    tick();
    chk("dup_keycode", keycode, 32'h00000007);

    // Overflow beyond four held keys
    do_clear();
    send(KEY_A, 1'b1);
    send(KEY_D, 1'b1);
    send(KEY_S, 1'b1);
    send(KEY_W, 1'b1);
    send(8'h2C, 1'b1);
    idle(3);
    chk("ovf_rollover", {31'b0, rollover}, {31'b0, ROLL_EN});
    tick();
    chk("ovf_keycode", keycode, ROLL_EN ? 32'h01010101 : 32'h1A160704);
    send(8'h2C, 1'b0);
    idle(3);
    chk("ovf_release_rollover", {31'b0, rollover}, 32'd0);
    tick();
    chk("ovf_release_keycode", keycode, 32'h1A160704);

    // Valid held high with a fresh code every cycle
    do_clear();
    acc_cnt = 0;
    for (int i = 0; i < 12; i++) begin
      ev_valid = 1'b1;
      ev_code  = 8'(8'h04 + i);
      ev_make  = 1'b1;
      #1;
      if (ev_ready) acc_cnt++;
      step();
    end
    ev_valid = 1'b0;
    chk("hs_accepts", 32'(acc_cnt), 32'd4);
    idle(3);
    chk("hs_key_count", {29'b0, key_count}, 32'd4);
    tick();
    chk("hs_keycode", keycode, 32'h0D0A0704);

    // Clear while the event is being matched
    do_clear();
    send(KEY_A, 1'b1);
    clear = 1'b1;
    step();
    clear = 1'b0;
    #1;
    chk("clr_ev_ready", {31'b0, ev_ready}, 32'd1);
    idle(3);
    chk("clr_key_count", {29'b0, key_count}, 32'd0);

    // Frame tick coincident with the table write
    send(KEY_W, 1'b1);
    idle(3);
    tick();
    chk("pre_tick_keycode", keycode, 32'h0000001A);
    send(KEY_A, 1'b1);
    step();
    tick();
    chk("tick_upd_keycode", keycode, 32'h0000001A);
    chk("tick_upd_key_count", {29'b0, key_count}, 32'd2);
    tick();
    chk("tick_after_keycode", keycode, 32'h0000041A);

    // Randomized traffic
    for (int i = 0; i < 2000; i++) begin
      ev_valid   = ($urandom % 2) == 0;
      ev_code    = codes[$urandom % 8];
      ev_make    = ($urandom % 2) == 0;
      frame_tick = ($urandom % 4) == 0;
      clear      = ($urandom % 60) == 0;
      Reset_n    = ($urandom % 700) != 0;
      step();
    end
    ev_valid   = 1'b0;
    frame_tick = 1'b0;
    clear      = 1'b0;
    Reset_n    = 1'b1;
    idle(5);
    chk_en = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
